// File: rtl/clock_freq_checker.sv
// ---------------------------------------------------------------------------
// clock_freq_checker
//
// Measures the period of a slow, clock-like signal (sig_in) in clk_in cycles
// and reports whether it matches the expected ratio DIV = f_in/f_exp within
// +/-TOL cycles. `locked` is raised after two consecutive in-range periods.
// `timeout` is raised (sticky until the next measurement) when no rising edge
// arrives within 2*DIV cycles.
//
// Optional feature macro: CLK_CHECKER_DUTY_EN
//   defined     -> high_time reports the sig_in high time of the last period
//   not defined -> high_time is tied to 0 and no high counter is built
//
// Ports
//   clk_in        in   reference clock, all logic on its rising edge
//   reset         in   asynchronous active-low reset
//   sig_in        in   monitored signal, asynchronous to clk_in
//   period        out  last measured period (clk_in cycles)
//   period_valid  out  one-cycle pulse when period is updated
//   high_time     out  high cycles within the last period (duty option)
//   locked        out  two consecutive in-range periods seen
//   timeout       out  no rising edge for 2*DIV cycles (sticky)
// ---------------------------------------------------------------------------
module clock_freq_checker #(
    parameter int f_in  = 100,
    parameter int f_exp = 25,
    parameter int TOL   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             timeout
);

    localparam int DIV  = f_in / f_exp;
    // Lower bound clamps at zero when the tolerance exceeds the ratio.
    localparam int LO_I = (DIV > TOL) ? (DIV - TOL) : 0;

    localparam logic [CNT_W-1:0] LO_C  = CNT_W'(LO_I);
    localparam logic [CNT_W-1:0] HI_C  = CNT_W'(DIV + TOL);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(2 * DIV);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    // -----------------------------------------------------------------------
    // Synchronizer and edge detect
    // -----------------------------------------------------------------------
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic rise;

    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // One-cycle pulse, coincident with s3 going high on the next edge.
    assign rise = s2_q & ~s3_q;

    // -----------------------------------------------------------------------
    // Measurement FSM
    // -----------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       match_q, match_d;
    logic [1:0]       match_inc;
    logic             in_range;

    // cnt_q holds the period length in the rise cycle, since the previous
    // rise cycle loaded it with 1.
    assign in_range  = (cnt_q >= LO_C) && (cnt_q <= HI_C);
    assign match_inc = (match_q == 2'd2) ? 2'd2 : (match_q + 2'd1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = timeout_q;
        match_d        = match_q;

        case (state_q)
            IDLE: begin
                // First edge only arms; there is no reference edge yet.
                if (rise) begin
                    cnt_d   = ONE_C;
                    state_d = MEASURE;
                end
            end

            MEASURE: begin
                if (rise) begin
                    // An edge in the same cycle the limit is reached still
                    // counts as a valid measurement.
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    cnt_d          = ONE_C;
                    timeout_d      = 1'b0;
                    if (in_range) begin
                        match_d  = match_inc;
                        locked_d = (match_inc == 2'd2);
                    end else begin
                        match_d  = 2'd0;
                        locked_d = 1'b0;
                    end
                end else if (cnt_q == TMO_C) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
            match_q        <= 2'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
            match_q        <= match_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

    // -----------------------------------------------------------------------
    // Optional high-time measurement
    // -----------------------------------------------------------------------
`ifdef CLK_CHECKER_DUTY_EN
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;

    // s3 is low in the rise cycle, so the counter restarts from 0 and the
    // high cycles that follow are all attributed to the new period.
    always_comb begin
        high_cnt_d  = high_cnt_q;
        high_time_d = high_time_q;
        if (rise) begin
            high_cnt_d = '0;
            if (state_q == MEASURE) begin
                high_time_d = high_cnt_q;
            end
        end else if ((state_q == MEASURE) && s3_q) begin
            high_cnt_d = high_cnt_q + ONE_C;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            high_cnt_q  <= '0;
            high_time_q <= '0;
        end else begin
            high_cnt_q  <= high_cnt_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_freq_checker.sv
// ---------------------------------------------------------------------------
// Bench for clock_freq_checker. Two instances share one stimulus stream:
// u_dut with default parameters (DIV=4, TOL=0) and u_dut_t1 with TOL=1.
// Each generated rising edge pushes the expected measurement it closes into
// a queue; entries are popped and compared when period_valid pulses.
// ---------------------------------------------------------------------------
module tb_clock_freq_checker;

    logic        clk;
    logic        reset;
    logic        sig;

    logic [15:0] per0, hi0, per1, hi1;
    logic        pv0, lk0, tmo0, pv1, lk1, tmo1;

    clock_freq_checker u_dut (
        .clk_in       (clk),
        .reset        (reset),
        .sig_in       (sig),
        .period       (per0),
        .period_valid (pv0),
        .high_time    (hi0),
        .locked       (lk0),
        .timeout      (tmo0)
    );

    clock_freq_checker #(.TOL(1)) u_dut_t1 (
        .clk_in       (clk),
        .reset        (reset),
        .sig_in       (sig),
        .period       (per1),
        .period_valid (pv1),
        .high_time    (hi1),
        .locked       (lk1),
        .timeout      (tmo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int per;
        int lk0;
        int lk1;
        int hi;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // reference model state
    bit   armed = 0;
    int   prev_len = 0;
    int   prev_h = 0;
    int   m0 = 0;
    int   m1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at each generated rising edge: the edge closes the previous
    // period (if the checker is armed) and opens a new one.
    task automatic model_edge(input int p, input int h);
        exp_t e;
        if (armed) begin
            m0 = (prev_len == 4) ? ((m0 == 2) ? 2 : m0 + 1) : 0;
            m1 = (prev_len >= 3 && prev_len <= 5) ? ((m1 == 2) ? 2 : m1 + 1) : 0;
            e.per = prev_len;
            e.lk0 = (m0 == 2) ? 1 : 0;
            e.lk1 = (m1 == 2) ? 1 : 0;
`ifdef CLK_CHECKER_DUTY_EN
            e.hi  = prev_h;
`else
            e.hi  = 0;
`endif
            sb.push_back(e);
        end
        armed    = 1;
        prev_len = p;
        prev_h   = h;
    endtask

    task automatic model_clear();
        armed = 0;
        m0    = 0;
        m1    = 0;
    endtask

    // One period: high for h cycles then low for p-h, edges at negedge.
    task automatic drive_period(input int p, input int h);
        model_edge(p, h);
        sig = 1'b1;
        repeat (h) @(negedge clk);
        sig = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic drive_n(input int n, input int p, input int h);
        for (int i = 0; i < n; i++) drive_period(p, h);
    endtask

    // scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (pv0 || pv1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pv", 32'(pv0 | pv1), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pv0", 32'(pv0), 32'd1);
                chk("pv1", 32'(pv1), 32'd1);
                chk("period0", 32'(per0), 32'(e.per));
                chk("period1", 32'(per1), 32'(e.per));
                chk("locked0", 32'(lk0), 32'(e.lk0));
                chk("locked1", 32'(lk1), 32'(e.lk1));
                chk("timeout0", 32'(tmo0), 32'd0);
                chk("timeout1", 32'(tmo1), 32'd0);
                chk("high0", 32'(hi0), 32'(e.hi));
                chk("high1", 32'(hi1), 32'(e.hi));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        sig   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", 32'(per0), 32'd0);
        chk("rst_pv", 32'(pv0), 32'd0);
        chk("rst_high", 32'(hi0), 32'd0);
        chk("rst_locked", 32'(lk0), 32'd0);
        chk("rst_timeout", 32'(tmo0), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // lock at 4, switch to 6, tolerance window on 5, back out at 6
        drive_n(3, 4, 2);
        drive_n(2, 6, 3);
        drive_n(3, 5, 2);
        drive_n(1, 6, 3);
        // minimum period, and the 2*DIV boundary where the edge wins
        drive_n(3, 2, 1);
        drive_n(2, 8, 4);
        // duty 1/3, relocks at 4
        drive_n(3, 4, 1);

        // timeout: sig held low after the last rise
        repeat (6) @(negedge clk);
        chk("sb_empty_pre_tmo", 32'(sb.size()), 32'd0);
        chk("tmo_early0", 32'(tmo0), 32'd0);
        chk("tmo_early1", 32'(tmo1), 32'd0);
        chk("lk_pre_tmo", 32'(lk0), 32'd1);
        @(negedge clk);
        chk("tmo_set0", 32'(tmo0), 32'd1);
        chk("tmo_set1", 32'(tmo1), 32'd1);
        chk("tmo_unlock0", 32'(lk0), 32'd0);
        chk("tmo_unlock1", 32'(lk1), 32'd0);
        model_clear();
        repeat (5) @(negedge clk);

        // resume: first edge only arms, timeout stays set
        drive_period(4, 2);
        chk("tmo_after_arm", 32'(tmo0), 32'd1);
        drive_n(3, 4, 2);
        chk("lk_pre_rst", 32'(lk0), 32'd1);

        // asynchronous reset mid-period while locked
        model_edge(4, 2);
        sig = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_period", 32'(per0), 32'd0);
        chk("arst_pv", 32'(pv0), 32'd0);
        chk("arst_locked0", 32'(lk0), 32'd0);
        chk("arst_locked1", 32'(lk1), 32'd0);
        chk("arst_timeout", 32'(tmo0), 32'd0);
        chk("arst_high", 32'(hi0), 32'd0);
        chk("sb_pending_at_rst", 32'(sb.size()), 32'd1);
        sb.delete();
        model_clear();
        sig = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        drive_n(3, 4, 2);

        repeat (12) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
